// File: rtl/kgp_seq_pkg.sv
// Shared definitions for the instruction sequencer: state codes,
// instruction class codes and the memory-wait timeout default.
package kgp_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } seq_state_t;

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_HALT   = 3'd4;

    localparam int SEQ_TIMEOUT_DEF = 16;

endpackage

// File: rtl/seq_timeout_cnt.sv
// Memory-wait watchdog: counts consecutive wait cycles, flags expiry.
// Ports: clk, rst (async active-low), waiting (in), expire (out).
module seq_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Expiry fires on the LIMIT-th consecutive wait cycle.
    assign expire = waiting && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (waiting) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT(/ERR).
// Ports: clk, rst (async active-low); in: instr_cls, alu_done, mem_ack,
//   resume; out: mem_req, mem_we, ir_we, reg_we, flags_we, pc_we, alu_go,
//   illegal, err, state_o.
// Option: define SEQ_MEM_TIMEOUT_EN to add the memory-wait timeout and
//   the sticky ERR state; otherwise err is tied low.
module instr_seq_ctrl
    import kgp_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = SEQ_TIMEOUT_DEF,
    parameter int CLS_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CLS_W-1:0] instr_cls,
    input  logic             alu_done,
    input  logic             mem_ack,
    input  logic             resume,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             flags_we,
    output logic             pc_we,
    output logic             alu_go,
    output logic             illegal,
    output logic             err,
    output logic [2:0]       state_o
);

    seq_state_t       state;
    seq_state_t       nxt;
    logic [CLS_W-1:0] cls_q;
    logic             run_q;
    logic             exec_wait_q;
    logic             expire;

    logic dec_ill;
    logic dec_halt;
    logic q_alu;
    logic q_load;
    logic q_store;
    logic q_branch;

    assign dec_ill  = int'(instr_cls) > int'(CLS_HALT);
    assign dec_halt = int'(instr_cls) == int'(CLS_HALT);
    assign q_alu    = int'(cls_q) == int'(CLS_ALU);
    assign q_load   = int'(cls_q) == int'(CLS_LOAD);
    assign q_store  = int'(cls_q) == int'(CLS_STORE);
    assign q_branch = int'(cls_q) == int'(CLS_BRANCH);

`ifdef SEQ_MEM_TIMEOUT_EN
    logic waiting;

    assign waiting = run_q && !mem_ack &&
                     ((state == ST_FETCH) || (state == ST_MEM));

    seq_timeout_cnt #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .waiting(waiting),
        .expire (expire)
    );
`else
    logic unused_cfg;

    assign expire     = 1'b0;
    assign unused_cfg = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            ST_FETCH: begin
                if (run_q && mem_ack) nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_ill)       nxt = ST_FETCH;
                else if (dec_halt) nxt = ST_HALT;
                else               nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (alu_done) begin
                    if (q_alu)                 nxt = ST_WB;
                    else if (q_load || q_store) nxt = ST_MEM;
                    else                       nxt = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (mem_ack) nxt = q_load ? ST_WB : ST_FETCH;
            end
            ST_WB:   nxt = ST_FETCH;
            ST_HALT: begin
                if (resume) nxt = ST_FETCH;
            end
            ST_ERR:  nxt = ST_ERR;
            default: nxt = ST_FETCH;
        endcase
        if (expire) nxt = ST_ERR;
    end

    // run_q holds everything quiet until the first edge after reset,
    // so reset alone drives all outputs low asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_FETCH;
            cls_q       <= '0;
            run_q       <= 1'b0;
            exec_wait_q <= 1'b0;
        end else begin
            state       <= nxt;
            run_q       <= 1'b1;
            exec_wait_q <= (state == ST_EXEC) && !alu_done;
            if (state == ST_DECODE) cls_q <= instr_cls;
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        flags_we = 1'b0;
        pc_we    = 1'b0;
        alu_go   = 1'b0;
        illegal  = 1'b0;
        err      = 1'b0;
        unique case (state)
            ST_FETCH: begin
                mem_req = run_q;
                ir_we   = run_q && mem_ack;
            end
            ST_DECODE: begin
                illegal = dec_ill;
                pc_we   = dec_ill;
            end
            ST_EXEC: begin
                alu_go = !exec_wait_q;
                pc_we  = alu_done && q_branch;
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = q_store;
                pc_we   = mem_ack && q_store;
            end
            ST_WB: begin
                reg_we   = 1'b1;
                pc_we    = 1'b1;
                flags_we = q_alu;
            end
            ST_ERR:  err = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Scoreboard bench for instr_seq_ctrl: per-cycle stimulus and expected
// output vectors are queued together and compared cycle by cycle.
module tb_instr_seq_ctrl;
    import kgp_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] instr_cls = 3'd0;
    logic       alu_done = 1'b0;
    logic       mem_ack = 1'b0;
    logic       resume = 1'b0;
    logic       mem_req, mem_we, ir_we, reg_we, flags_we;
    logic       pc_we, alu_go, illegal, err;
    logic [2:0] state_o;

    instr_seq_ctrl #(
        .TIMEOUT_CYC(16),
        .CLS_W      (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .instr_cls(instr_cls),
        .alu_done (alu_done),
        .mem_ack  (mem_ack),
        .resume   (resume),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .ir_we    (ir_we),
        .reg_we   (reg_we),
        .flags_we (flags_we),
        .pc_we    (pc_we),
        .alu_go   (alu_go),
        .illegal  (illegal),
        .err      (err),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] RQ = 12'h800;
    localparam logic [11:0] WE = 12'h400;
    localparam logic [11:0] IR = 12'h200;
    localparam logic [11:0] RG = 12'h100;
    localparam logic [11:0] FL = 12'h080;
    localparam logic [11:0] PC = 12'h040;
    localparam logic [11:0] GO = 12'h020;
    localparam logic [11:0] IL = 12'h010;
    localparam logic [11:0] ER = 12'h008;
    localparam logic [11:0] NO = 12'h000;

    typedef struct packed {
        logic [2:0] cls;
        logic       ack;
        logic       done;
        logic       res;
    } stim_t;

    stim_t       sq[$];
    logic [11:0] eq[$];
    string       tq[$];

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [11:0] obs();
        return {mem_req, mem_we, ir_we, reg_we, flags_we, pc_we,
                alu_go, illegal, err, state_o};
    endfunction

    task automatic chk(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp,
                     $time);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] c,
                        input logic a, input logic d, input logic r,
                        input seq_state_t s, input logic [11:0] bits);
        sq.push_back('{cls: c, ack: a, done: d, res: r});
        eq.push_back(bits | {9'd0, s});
        tq.push_back(tag);
    endtask

    // Expected per-cycle timeline of one instruction.
    task automatic gen(input logic [2:0] c, input int fd, input int ad,
                       input int md, input logic tie);
        logic isa, isl, iss, isb;
        isa = (c == 3'd0);
        isl = (c == 3'd1);
        iss = (c == 3'd2);
        isb = (c == 3'd3);
        for (int i = 0; i < fd; i++)
            push("fetch_wait", c, 1'b0, 1'b0, 1'b0, ST_FETCH, RQ);
        push("fetch_ack", c, 1'b1, tie, 1'b0, ST_FETCH, RQ | IR);
        if (c > 3'd4) begin
            push("decode_ill", c, tie, tie, 1'b0, ST_DECODE, IL | PC);
            return;
        end
        if (c == 3'd4) begin
            push("decode_halt", c, 1'b0, 1'b0, 1'b0, ST_DECODE, NO);
            for (int i = 0; i < 10; i++)
                push("halt_hold", c, 1'b1, 1'b1, 1'b0, ST_HALT, NO);
            push("halt_resume", c, 1'b0, 1'b0, 1'b1, ST_HALT, NO);
            return;
        end
        push("decode", c, tie, tie, 1'b0, ST_DECODE, NO);
        for (int i = 0; i < ad; i++)
            push("exec_wait", c, 1'b0, 1'b0, 1'b1, ST_EXEC,
                 (i == 0) ? GO : NO);
        push("exec_done", c, tie, 1'b1, 1'b0, ST_EXEC,
             ((ad == 0) ? GO : NO) | (isb ? PC : NO));
        if (isb) return;
        if (isa) begin
            push("wb_alu", c, tie, tie, 1'b0, ST_WB, RG | PC | FL);
            return;
        end
        for (int i = 0; i < md; i++)
            push("mem_wait", c, 1'b0, 1'b0, 1'b0, ST_MEM,
                 RQ | (iss ? WE : NO));
        push("mem_ack", c, 1'b1, tie, 1'b0, ST_MEM,
             RQ | (iss ? (WE | PC) : NO));
        if (isl)
            push("wb_load", c, tie, tie, 1'b0, ST_WB, RG | PC);
    endtask

    task automatic step();
        stim_t       s;
        logic [11:0] e;
        string       t;
        s = sq.pop_front();
        e = eq.pop_front();
        t = tq.pop_front();
        @(negedge clk);
        instr_cls = s.cls;
        mem_ack   = s.ack;
        alu_done  = s.done;
        resume    = s.res;
        #2;
        chk(t, obs(), e);
    endtask

    task automatic drain();
        while (sq.size() > 0) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("reset", obs(), {9'd0, ST_FETCH});
        @(negedge clk);
        #2;
        chk("reset_held", obs(), {9'd0, ST_FETCH});
        #1 rst = 1'b1;
        #1 chk("pre_first_edge", obs(), {9'd0, ST_FETCH});

        gen(3'd0, 0, 0, 0, 1'b1);
        gen(3'd1, 0, 0, 3, 1'b0);
        gen(3'd2, 2, 1, 1, 1'b0);
        gen(3'd3, 0, 2, 0, 1'b0);
        gen(3'd4, 1, 0, 0, 1'b0);
        gen(3'd6, 0, 0, 0, 1'b0);
        gen(3'd0, 1, 3, 0, 1'b0);
        for (int k = 0; k < 6; k++)
            gen(3'($urandom_range(0, 3)), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        drain();

        // Abort a LOAD while it waits in MEM.
        gen(3'd1, 0, 0, 3, 1'b0);
        for (int i = 0; i < 4; i++) step();
        sq.delete();
        eq.delete();
        tq.delete();
        #1 rst = 1'b0;
        #1 chk("rst_async", obs(), {9'd0, ST_FETCH});
        @(negedge clk);
        mem_ack = 1'b0;
        #2;
        chk("rst_mid", obs(), {9'd0, ST_FETCH});
        #1 rst = 1'b1;
        #1 chk("rst_release", obs(), {9'd0, ST_FETCH});
        gen(3'd0, 1, 0, 0, 1'b0);
        drain();

        for (int i = 0; i < 16; i++)
            push("to_wait", 3'd0, 1'b0, 1'b0, 1'b0, ST_FETCH, RQ);
`ifdef SEQ_MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++)
            push("to_err", 3'd0, 1'b1, 1'b1, 1'b1, ST_ERR, ER);
`else
        for (int i = 0; i < 4; i++)
            push("to_still_wait", 3'd0, 1'b0, 1'b0, 1'b0, ST_FETCH, RQ);
`endif
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec,
                 n_bad);
        $finish;
    end

endmodule

// File: doc/instr_seq_ctrl.md
INSTR_SEQ_CTRL -- requirements
Module: instr_seq_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16, memory-wait cycles before error (used only with SEQ_MEM_TIMEOUT_EN).
REQ-002 Parameter: CLS_W, default 3, width of the instruction-class input.
REQ-003 Clocking SHALL be one clock, clk; reset SHALL be rst, asynchronous and active-low.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 instr_cls  in  CLS_W  decoded class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 HALT, 5-7 illegal.
REQ-007 alu_done  in  1  ALU result valid (level).
REQ-008 mem_ack  in  1  memory completes the current request this cycle.
REQ-009 resume  in  1  single-cycle pulse that leaves HALT.
REQ-010 mem_req, mem_we  out  1 each  memory request, write qualifier.
REQ-011 ir_we, reg_we, flags_we, pc_we, alu_go  out  1 each  datapath enables.
REQ-012 illegal, err  out  1 each  illegal-class pulse, sticky timeout error.
REQ-013 state_o  out  3  current state code (debug).

Function
REQ-014 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT and ERR; outputs SHALL be decoded from the state register plus same-cycle mem_ack/alu_done only.
REQ-015 FETCH: mem_req=1, mem_we=0; on mem_ack: ir_we=1 that cycle, go to DECODE; otherwise hold.
REQ-016 DECODE: one cycle; latch instr_cls into cls_q.
REQ-017 DECODE transitions: classes 0-3 go to EXEC; class 4 goes to HALT; classes 5-7 assert illegal and pc_we for one cycle, then go to FETCH.
REQ-018 EXEC: alu_go=1 in the first EXEC cycle only; wait for alu_done.
REQ-019 EXEC on alu_done: ALU goes to WB; LOAD or STORE goes to MEM; BRANCH asserts pc_we and goes to FETCH.
REQ-020 MEM: mem_req=1, mem_we=(cls_q==STORE).
REQ-021 MEM on mem_ack: LOAD goes to WB; STORE asserts pc_we and goes to FETCH.
REQ-022 WB: one cycle with reg_we=1 and pc_we=1; flags_we=1 only when cls_q==ALU; then go to FETCH.
REQ-023 HALT: all enables 0; resume goes to FETCH; resume outside HALT SHALL be ignored.
REQ-024 Best-case ALU latency SHALL be 4 cycles (FETCH-DECODE-EXEC-WB) when mem_ack and alu_done are high on first sample; LOAD best case 5, STORE 4, BRANCH 3.
REQ-025 Every enable SHALL be a single-cycle pulse per instruction; mem_req SHALL stay high until acked and SHALL drop the cycle after ack.

Reset
REQ-026 rst low SHALL force FETCH, cls_q=0, timeout count 0 and err=0 immediately, aborting any operation in flight.
REQ-027 During reset all outputs SHALL be 0 except state_o=FETCH code.
REQ-028 mem_req SHALL first assert on the first clk edge after rst deasserts.

Configuration
REQ-029 With SEQ_MEM_TIMEOUT_EN defined, a counter SHALL count cycles in FETCH/MEM without mem_ack and clear on ack or state change.
REQ-030 With SEQ_MEM_TIMEOUT_EN defined, reaching TIMEOUT_CYC SHALL move to ERR: err=1, all enables 0, exit only via reset.
REQ-031 Without SEQ_MEM_TIMEOUT_EN, there SHALL be no counter and no ERR state; err SHALL be tied 0 and memory waits are unbounded.

Structure
REQ-032 Package kgp_seq_pkg SHALL hold the state encoding, the class codes (ALU..HALT) and the TIMEOUT_CYC default.
REQ-033 The timeout counter SHALL be sub-module seq_timeout_cnt, instantiated only under SEQ_MEM_TIMEOUT_EN.

Verification
REQ-034 ALU, ack and alu_done tied high -> ir_we@1, alu_go@3, reg_we+flags_we+pc_we@4, mem_req again @5.
REQ-035 LOAD, MEM ack delayed 3 cycles -> mem_req high 4 cycles with mem_we=0, then reg_we one cycle, flags_we=0.
REQ-036 STORE then BRANCH -> mem_we=1 only in MEM; BRANCH pc_we in EXEC with no reg_we/flags_we.
REQ-037 Class 4 -> HALT held 10 cycles with no enables; resume -> FETCH next cycle. Class 6 -> illegal+pc_we one pulse.
REQ-038 rst pulled low mid-MEM -> outputs 0 asynchronously; after release, FETCH with no stale pc_we/reg_we.
REQ-039 With SEQ_MEM_TIMEOUT_EN, TIMEOUT_CYC=16 and ack withheld -> err=1 after 16 wait cycles and stays set; without the macro -> no err, still waiting.
